// File: rtl/rf_port_arbiter.sv
// Two-client arbiter in front of a single-ported register file.
// Serialises reads, writes and full-file clears; read data returns two cycles after grant.
module rf_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic        a_we,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_wdata,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic        b_we,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_wdata,

    input  logic        clr_req,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        busy,

    output logic [31:0] rf_in,
    output logic [4:0]  rf_in_addr,
    output logic [4:0]  rf_o1_addr,
    output logic [4:0]  rf_o2_addr,
    output logic        rf_read,
    output logic        rf_write,
    output logic        rf_enable,
    output logic        rf_reset,
    input  logic [31:0] rf_o1
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp,
        StClear
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        id_q, id_d;
    logic        clr_pending_q, clr_pending_d;
    logic        last_b_q, last_b_d;
    logic        grant_a, grant_b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            id_q          <= 1'b0;
            clr_pending_q <= 1'b0;
            last_b_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            id_q          <= id_d;
            clr_pending_q <= clr_pending_d;
            last_b_q      <= last_b_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        id_d          = id_q;
        clr_pending_d = clr_pending_q;
        last_b_d      = last_b_q;
        grant_a       = 1'b0;
        grant_b       = 1'b0;

        rf_in         = wdata_q;
        rf_in_addr    = addr_q;
        rf_o1_addr    = addr_q;
        rf_o2_addr    = addr_q;
        rf_read       = 1'b0;
        rf_write      = 1'b0;
        rf_enable     = 1'b0;
        rf_reset      = reset;
        rsp_valid     = 1'b0;
        rsp_id        = id_q;
        rsp_data      = '0;

        unique case (state_q)
            StIdle: begin
                if (clr_req || clr_pending_q) begin
                    state_d = StClear;
                end else if (a_valid || b_valid) begin
                    // Round-robin: A wins a contest only if B took the previous grant.
                    if (FIXED_PRIO) begin
                        grant_a = a_valid;
                    end else begin
                        grant_a = a_valid && (!b_valid || last_b_q);
                    end
                    grant_b  = !grant_a;
                    we_d     = grant_b ? b_we    : a_we;
                    addr_d   = grant_b ? b_addr  : a_addr;
                    wdata_d  = grant_b ? b_wdata : a_wdata;
                    id_d     = grant_b;
                    last_b_d = grant_b;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                rf_enable = reset;
                rf_write  = reset && we_q;
                rf_read   = reset && !we_q;
                state_d   = we_q ? StIdle : StResp;
                if (clr_req) begin
                    clr_pending_d = 1'b1;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_data  = rf_o1;
                state_d   = StIdle;
                if (clr_req) begin
                    clr_pending_d = 1'b1;
                end
            end
            StClear: begin
                // A clr_req arriving during the clear is satisfied by this clear.
                rf_reset      = 1'b0;
                clr_pending_d = 1'b0;
                state_d       = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        a_ready = reset && grant_a;
        b_ready = reset && grant_b;
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Bench for rf_port_arbiter: round-robin and fixed-priority instances, each with a register
// file model, checked every cycle against a transaction-level reference model.
module tb_rf_port_arbiter;

    localparam int unsigned NumInst = 2;  // 0: round-robin, 1: fixed priority

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        a_valid [NumInst];
    logic        b_valid [NumInst];
    logic        a_we    [NumInst];
    logic        b_we    [NumInst];
    logic [4:0]  a_addr  [NumInst];
    logic [4:0]  b_addr  [NumInst];
    logic [31:0] a_wdata [NumInst];
    logic [31:0] b_wdata [NumInst];
    logic        clr_req [NumInst];
    logic        a_ready [NumInst];
    logic        b_ready [NumInst];
    logic        rsp_valid [NumInst];
    logic        rsp_id    [NumInst];
    logic [31:0] rsp_data  [NumInst];
    logic        busy      [NumInst];
    logic [31:0] rf_in      [NumInst];
    logic [4:0]  rf_in_addr [NumInst];
    logic [4:0]  rf_o1_addr [NumInst];
    logic [4:0]  rf_o2_addr [NumInst];
    logic        rf_read    [NumInst];
    logic        rf_write   [NumInst];
    logic        rf_enable  [NumInst];
    logic        rf_reset   [NumInst];
    logic [31:0] rf_o1      [NumInst];

    rf_port_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_we(a_we[0]), .a_addr(a_addr[0]),
        .a_wdata(a_wdata[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_we(b_we[0]), .b_addr(b_addr[0]),
        .b_wdata(b_wdata[0]),
        .clr_req(clr_req[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]),
        .rf_in(rf_in[0]), .rf_in_addr(rf_in_addr[0]), .rf_o1_addr(rf_o1_addr[0]),
        .rf_o2_addr(rf_o2_addr[0]), .rf_read(rf_read[0]), .rf_write(rf_write[0]),
        .rf_enable(rf_enable[0]), .rf_reset(rf_reset[0]), .rf_o1(rf_o1[0])
    );

    rf_port_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_we(a_we[1]), .a_addr(a_addr[1]),
        .a_wdata(a_wdata[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_we(b_we[1]), .b_addr(b_addr[1]),
        .b_wdata(b_wdata[1]),
        .clr_req(clr_req[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]),
        .rf_in(rf_in[1]), .rf_in_addr(rf_in_addr[1]), .rf_o1_addr(rf_o1_addr[1]),
        .rf_o2_addr(rf_o2_addr[1]), .rf_read(rf_read[1]), .rf_write(rf_write[1]),
        .rf_enable(rf_enable[1]), .rf_reset(rf_reset[1]), .rf_o1(rf_o1[1])
    );

    // Register file with registered read port, one per instance.
    logic [31:0] rf_mem [NumInst][32];
    always @(posedge clk) begin
        for (int g = 0; g < NumInst; g++) begin
            if (!rf_reset[g]) begin
                for (int i = 0; i < 32; i++) rf_mem[g][i] <= '0;
                rf_o1[g] <= '0;
            end else if (rf_enable[g]) begin
                if (rf_write[g]) rf_mem[g][rf_in_addr[g]] <= rf_in[g];
                if (rf_read[g])  rf_o1[g] <= rf_mem[g][rf_o1_addr[g]];
            end
        end
    end

    // Reference model: operations take effect in grant order; counters track occupancy.
    int          busy_cnt [NumInst];
    int          rsp_cnt  [NumInst];
    bit          busy_clr [NumInst];
    bit          pend     [NumInst];
    bit          last_a   [NumInst];
    bit          exp_id   [NumInst];
    logic [31:0] exp_data [NumInst];
    logic [31:0] ref_mem  [NumInst][32];
    bit          a_acc    [NumInst];
    bit          b_acc    [NumInst];
    bit          rand_mode;
    bit          hold_mode;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_cycle(input int k);
        bit          free, clr_take, win_a, win_b, we;
        logic [4:0]  addr;
        logic [31:0] data;
        free     = (busy_cnt[k] == 0);
        clr_take = reset && free && (clr_req[k] || pend[k]);
        win_a    = 1'b0;
        win_b    = 1'b0;
        if (reset && free && !clr_take && (a_valid[k] || b_valid[k])) begin
            if (k == 1)                         win_a = a_valid[k];
            else if (a_valid[k] && b_valid[k])  win_a = !last_a[k];
            else                                win_a = a_valid[k];
            win_b = !win_a;
        end

        chk($sformatf("a_ready[%0d]", k), 32'(a_ready[k]), 32'(win_a));
        chk($sformatf("b_ready[%0d]", k), 32'(b_ready[k]), 32'(win_b));
        chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(busy_cnt[k] > 0));
        chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'(rsp_cnt[k] == 1));
        chk($sformatf("rf_reset[%0d]", k), 32'(rf_reset[k]),
            32'(reset && !(busy_cnt[k] > 0 && busy_clr[k])));
        if (rsp_cnt[k] == 1) begin
            chk($sformatf("rsp_id[%0d]", k), 32'(rsp_id[k]), 32'(exp_id[k]));
            chk($sformatf("rsp_data[%0d]", k), rsp_data[k], exp_data[k]);
        end
        a_acc[k] = a_ready[k];
        b_acc[k] = b_ready[k];

        if (!reset) begin
            busy_cnt[k] = 0;
            rsp_cnt[k]  = 0;
            busy_clr[k] = 1'b0;
            pend[k]     = 1'b0;
            last_a[k]   = 1'b0;
            for (int i = 0; i < 32; i++) ref_mem[k][i] = '0;
        end else begin
            if (clr_take) begin
                for (int i = 0; i < 32; i++) ref_mem[k][i] = '0;
                pend[k]     = 1'b0;
                busy_cnt[k] = 2;
                busy_clr[k] = 1'b1;
            end else if (win_a || win_b) begin
                we   = win_a ? a_we[k]    : b_we[k];
                addr = win_a ? a_addr[k]  : b_addr[k];
                data = win_a ? a_wdata[k] : b_wdata[k];
                if (we) begin
                    ref_mem[k][addr] = data;
                    busy_cnt[k]      = 2;
                end else begin
                    exp_data[k] = ref_mem[k][addr];
                    exp_id[k]   = win_b;
                    rsp_cnt[k]  = 3;
                    busy_cnt[k] = 3;
                end
                busy_clr[k] = 1'b0;
                last_a[k]   = win_a;
            end else if (!free && clr_req[k] && !busy_clr[k]) begin
                pend[k] = 1'b1;
            end
            if (busy_cnt[k] > 0) busy_cnt[k]--;
            if (rsp_cnt[k] > 0)  rsp_cnt[k]--;
        end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    task automatic client_next(input int k);
        if (a_acc[k] && !hold_mode && !rand_mode) a_valid[k] = 1'b0;
        if (b_acc[k] && !hold_mode && !rand_mode) b_valid[k] = 1'b0;
        if (rand_mode && (a_acc[k] || !a_valid[k])) begin
            a_valid[k] = ($urandom_range(0, 9) < 6);
            a_we[k]    = 1'($urandom_range(0, 1));
            a_addr[k]  = rand_addr();
            a_wdata[k] = $urandom();
        end
        if (rand_mode && (b_acc[k] || !b_valid[k])) begin
            b_valid[k] = ($urandom_range(0, 9) < 6);
            b_we[k]    = 1'($urandom_range(0, 1));
            b_addr[k]  = rand_addr();
            b_wdata[k] = $urandom();
        end
        clr_req[k] = rand_mode ? ($urandom_range(0, 19) == 0) : 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        for (int k = 0; k < NumInst; k++) model_cycle(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < NumInst; k++) client_next(k);
        if (rand_mode) reset = ($urandom_range(0, 249) != 0);
    endtask

    task automatic set_req(input bit side_b, input bit we, input logic [4:0] addr,
                           input logic [31:0] data);
        for (int k = 0; k < NumInst; k++) begin
            if (side_b) begin
                b_valid[k] = 1'b1; b_we[k] = we; b_addr[k] = addr; b_wdata[k] = data;
            end else begin
                a_valid[k] = 1'b1; a_we[k] = we; a_addr[k] = addr; a_wdata[k] = data;
            end
        end
    endtask

    task automatic drop_all();
        for (int k = 0; k < NumInst; k++) begin
            a_valid[k] = 1'b0;
            b_valid[k] = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        for (int k = 0; k < NumInst; k++) clr_req[k] = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rand_mode = 1'b0;
        hold_mode = 1'b0;
        reset     = 1'b0;
        for (int k = 0; k < NumInst; k++) begin
            a_valid[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
            b_valid[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
            clr_req[k] = 1'b0;
        end
        repeat (2) step();
        reset = 1'b1;
        step();

        // A write/read of address 30.
        set_req(1'b0, 1'b1, 5'd30, 32'd111111);
        repeat (3) step();
        set_req(1'b0, 1'b0, 5'd30, 32'd0);
        repeat (4) step();

        // B write/read of address 10.
        set_req(1'b1, 1'b1, 5'd10, 32'd9999999);
        repeat (3) step();
        set_req(1'b1, 1'b0, 5'd10, 32'd0);
        repeat (4) step();

        // Continuous contention: alternation on instance 0, A only on instance 1.
        hold_mode = 1'b1;
        set_req(1'b0, 1'b0, 5'd1, 32'd0);
        set_req(1'b1, 1'b0, 5'd2, 32'd0);
        repeat (12) step();
        hold_mode = 1'b0;
        drop_all();
        repeat (4) step();

        // Clear requested during a read's ACCESS: response first, then clear.
        set_req(1'b0, 1'b0, 5'd10, 32'd0);
        step();
        pulse_clr();
        repeat (4) step();
        set_req(1'b0, 1'b0, 5'd10, 32'd0);
        repeat (4) step();

        // Reset during RESP: response suppressed afterwards, file reads back all zero.
        set_req(1'b1, 1'b1, 5'd10, 32'd5555);
        repeat (3) step();
        set_req(1'b0, 1'b0, 5'd10, 32'd0);
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int a = 0; a < 32; a++) begin
            set_req(1'b0, 1'b0, 5'(a), 32'd0);
            repeat (3) step();
        end

        // Randomised traffic with clears and occasional resets.
        rand_mode = 1'b1;
        repeat (4000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
